// File: rtl/uart_tx_pkg.sv
// Shared types and defaults for the serial transmitter.
package uart_tx_pkg;

    localparam int DATA_WD_DEF = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

endpackage

// File: rtl/uart_tx_parity.sv
// Frame parity bit: XOR of the data bits, inverted when odd parity is selected.
module uart_tx_parity #(
    parameter int DATA_WD = 8
) (
    input  logic [DATA_WD-1:0] data,
    input  logic               par_type,
    output logic               par_bit
);

    assign par_bit = (^data) ^ par_type;

endmodule

// File: rtl/uart_tx.sv
// One-bit-per-clock UART transmitter: start, DATA_WD bits LSB first, optional parity, stop.
// Parity support is compiled in only when UART_TX_PARITY_EN is defined.
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int DATA_WD = DATA_WD_DEF
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [DATA_WD-1:0] P_DATA,
    input  logic               Data_Valid,
    input  logic               parity_enable,
    input  logic               parity_type,
    output logic               TX_OUT,
    output logic               busy
);

    localparam int CNT_W = (DATA_WD > 1) ? $clog2(DATA_WD) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_WD - 1);

    state_t             state, state_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic [DATA_WD-1:0] data_q;
    logic               accept;
    logic               tx_d, busy_d;

    assign accept = (state == IDLE) && Data_Valid;

`ifdef UART_TX_PARITY_EN
    logic par_en_q, par_type_q, par_bit;

    always_ff @(posedge CLK) begin
        if (RST) begin
            par_en_q   <= 1'b0;
            par_type_q <= 1'b0;
        end else if (accept) begin
            par_en_q   <= parity_enable;
            par_type_q <= parity_type;
        end
    end

    uart_tx_parity #(.DATA_WD(DATA_WD)) u_parity (
        .data     (data_q),
        .par_type (par_type_q),
        .par_bit  (par_bit)
    );
`else
    logic unused_parity_cfg;
    assign unused_parity_cfg = parity_enable ^ parity_type;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE: begin
                if (Data_Valid) begin
                    state_nx = START;
                    cnt_nx   = '0;
                end
            end
            START: state_nx = DATA;
            DATA: begin
                if (cnt == LAST) begin
                    cnt_nx = '0;
`ifdef UART_TX_PARITY_EN
                    state_nx = par_en_q ? PARITY : STOP;
`else
                    state_nx = STOP;
`endif
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            PARITY: state_nx = STOP;
            STOP:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Line and busy are computed from the upcoming state so both registers
    // change on the same edge as the state itself.
    always_comb begin
        tx_d   = 1'b1;
        busy_d = 1'b1;
        case (state_nx)
            IDLE:  busy_d = 1'b0;
            START: tx_d   = 1'b0;
            DATA:  tx_d   = data_q[cnt_nx];
`ifdef UART_TX_PARITY_EN
            PARITY: tx_d  = par_bit;
`endif
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            TX_OUT <= 1'b1;
            busy   <= 1'b0;
            data_q <= '0;
        end else begin
            TX_OUT <= tx_d;
            busy   <= busy_d;
            if (accept)
                data_q <= P_DATA;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: frame-list model compared every cycle plus literal frames.
module tb_uart_tx;

    localparam int W = 8;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic [W-1:0] P_DATA = '0;
    logic         Data_Valid = 1'b0;
    logic         parity_enable = 1'b0;
    logic         parity_type = 1'b0;
    logic         TX_OUT;
    logic         busy;

    uart_tx #(.DATA_WD(W)) dut (
        .CLK           (CLK),
        .RST           (RST),
        .P_DATA        (P_DATA),
        .Data_Valid    (Data_Valid),
        .parity_enable (parity_enable),
        .parity_type   (parity_type),
        .TX_OUT        (TX_OUT),
        .busy          (busy)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: on acceptance build the whole frame as a list of line values,
    // then play one entry per clock; busy while entries remain on the line.
    bit frame_q[$];
    bit exp_tx = 1'b1;
    bit exp_busy = 1'b0;
    bit chk_en = 1'b0;

    always @(posedge CLK) begin
        if (RST) begin
            frame_q.delete();
            exp_tx   = 1'b1;
            exp_busy = 1'b0;
        end else if (!exp_busy && Data_Valid) begin
            frame_q.delete();
            frame_q.push_back(1'b0);
            for (int i = 0; i < W; i++)
                frame_q.push_back(P_DATA[i]);
`ifdef UART_TX_PARITY_EN
            if (parity_enable)
                frame_q.push_back(bit'(($countones(P_DATA) % 2) != 0) ^ parity_type);
`endif
            frame_q.push_back(1'b1);
            exp_tx   = frame_q.pop_front();
            exp_busy = 1'b1;
        end else if (exp_busy) begin
            if (frame_q.size() > 0) begin
                exp_tx = frame_q.pop_front();
            end else begin
                exp_tx   = 1'b1;
                exp_busy = 1'b0;
            end
        end
    end

    always @(negedge CLK) begin
        if (chk_en) begin
            n_cmp++;
            if (TX_OUT !== exp_tx || busy !== exp_busy) begin
                n_bad++;
                $display("FAIL model t=%0t tx=%b busy=%b required tx=%b busy=%b",
                         $time, TX_OUT, busy, exp_tx, exp_busy);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
        n_cmp++;
        if (got !== req) begin
            n_bad++;
            $display("FAIL %s got=%0d required=%0d", name, got, req);
        end
    endtask

    bit exp_seq[$];

    // Send one word and compare the line, sampled once per cycle starting
    // with the cycle after the accepting edge, against exp_seq.
    task automatic run(input string name, input logic [W-1:0] d, input bit pe, input bit pt,
                       input int inj, input int rst_at, input bit hold, input int req_busy);
        int nb;
        nb = 0;
        @(posedge CLK); #2;
        P_DATA = d; parity_enable = pe; parity_type = pt; Data_Valid = 1'b1;
        @(posedge CLK); #2;
        if (!hold) begin
            Data_Valid    = 1'b0;
            P_DATA        = ~d;
            parity_enable = ~pe;
            parity_type   = ~pt;
        end
        for (int i = 0; i < exp_seq.size(); i++) begin
            @(negedge CLK);
            chk($sformatf("%s tx[%0d]", name, i), 32'(TX_OUT), 32'(exp_seq[i]));
            if (busy === 1'b1) nb++;
            #1;
            if (inj >= 0 && i == inj) begin
                Data_Valid = 1'b1;
                P_DATA     = 8'h55;
            end else if (inj >= 0 && i == inj + 1) begin
                Data_Valid = 1'b0;
            end
            if (rst_at >= 0 && i == rst_at) RST = 1'b1;
            else if (rst_at >= 0 && i == rst_at + 1) RST = 1'b0;
        end
        if (hold) Data_Valid = 1'b0;
        chk({name, " busy cycles"}, 32'(nb), 32'(req_busy));
    endtask

    initial begin
        logic [W-1:0] extra [5];
        extra = '{8'h00, 8'hFF, 8'h01, 8'h80, 8'h5A};

        // Reset held together with Data_Valid: reset must win.
        RST = 1'b1; Data_Valid = 1'b1; P_DATA = 8'hFF;
        @(posedge CLK); #1 chk_en = 1'b1;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("reset tx", 32'(TX_OUT), 32'd1);
        chk("reset busy", 32'(busy), 32'd0);
        #1 RST = 1'b0; Data_Valid = 1'b0;

        exp_seq = '{0,1,1,0,0,0,1,0,1,1,1};
        run("A3 no parity", 8'hA3, 1'b0, 1'b0, -1, -1, 1'b0, 10);

`ifdef UART_TX_PARITY_EN
        exp_seq = '{0,0,0,1,0,1,1,0,1,0,1,1};
        run("B4 even", 8'hB4, 1'b1, 1'b0, -1, -1, 1'b0, 11);
        exp_seq = '{0,0,1,0,0,1,0,1,1,1,1,1};
        run("D2 odd", 8'hD2, 1'b1, 1'b1, -1, -1, 1'b0, 11);
`else
        exp_seq = '{0,0,0,1,0,1,1,0,1,1,1};
        run("B4 parity ignored", 8'hB4, 1'b1, 1'b0, -1, -1, 1'b0, 10);
`endif

        exp_seq = '{0,1,1,0,0,0,1,0,1,1,1};
        run("A3 with 55 mid-frame", 8'hA3, 1'b0, 1'b0, 3, -1, 1'b0, 10);

        exp_seq = '{0,1,1,0,0,1,1,1,1,1,1};
        run("A3 reset at bit3", 8'hA3, 1'b0, 1'b0, -1, 4, 1'b0, 5);

        exp_seq = '{0,1,1,0,0,0,1,0,1,1,1};
        run("A3 after reset", 8'hA3, 1'b0, 1'b0, -1, -1, 1'b0, 10);

        exp_seq = '{0,1,1,0,0,0,1,0,1,1, 1, 0,1,1,0,0,0,1,0,1,1, 1};
        run("A3 held valid", 8'hA3, 1'b0, 1'b0, -1, -1, 1'b1, 20);

        // Extra words checked by the model only.
        for (int k = 0; k < 5; k++) begin
            @(posedge CLK); #2;
            P_DATA = extra[k]; parity_enable = k[0]; parity_type = k[1]; Data_Valid = 1'b1;
            @(posedge CLK); #2;
            Data_Valid = 1'b0;
            repeat (W + 4) @(posedge CLK);
        end

        repeat (3) @(posedge CLK);
        @(negedge CLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter DATA_WD, default 8, SHALL set the parallel data width (number of data bits per frame).
REQ-002 CLK  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 RST  input  1  SHALL be a synchronous, active-high reset.
REQ-004 P_DATA  input  DATA_WD  SHALL carry the parallel word to transmit.
REQ-005 Data_Valid  input  1  SHALL be the one-cycle load strobe for P_DATA.
REQ-006 parity_enable  input  1  SHALL select a parity bit in the frame: 1 = present, 0 = absent.
REQ-007 parity_type  input  1  SHALL select parity type: 0 = even, 1 = odd.
REQ-008 TX_OUT  output  1  SHALL be the registered serial line, idle high.
REQ-009 busy  output  1  SHALL be a registered flag, high while a frame is on the line.

Function
REQ-010 Bit rate SHALL be one bit per CLK cycle (no baud divider).
REQ-011 Frame SHALL be: start (0), DATA_WD data bits LSB first, optional parity bit, stop (1).
REQ-012 Data_Valid SHALL be accepted only on a rising edge where busy=0; that edge SHALL latch P_DATA, parity_enable and parity_type.
REQ-013 On the accepting edge, TX_OUT SHALL go 0 (start bit) and busy SHALL go 1, both together.
REQ-014 Later input changes SHALL NOT affect a frame in progress; Data_Valid while busy=1 SHALL be ignored (no queuing).
REQ-015 Even parity bit SHALL be XOR of the latched data bits; odd parity SHALL be its inverse.
REQ-016 FSM states: IDLE, START, DATA, PARITY, STOP.
REQ-017 FSM transitions: IDLE->START on accept; START->DATA after 1 cycle; DATA->PARITY (parity on) or ->STOP (parity off) after DATA_WD cycles; PARITY->STOP after 1 cycle; STOP->IDLE after 1 cycle.
REQ-018 busy SHALL be 1 in START, DATA, PARITY and STOP, and 0 in IDLE.
REQ-019 TX_OUT SHALL be 1 in IDLE and STOP.
REQ-020 busy SHALL fall, with TX_OUT staying 1, on the edge ending the stop bit.
REQ-021 Minimum spacing between frames SHALL be 1 idle cycle; the next Data_Valid is accepted in the first cycle with busy=0.
REQ-022 Busy time SHALL be exactly DATA_WD+3 cycles with parity and DATA_WD+2 without.
REQ-023 The data bit counter SHALL be $clog2(DATA_WD) bits wide and SHALL clear at each frame start.

Reset
REQ-024 With RST=1 at a rising edge: FSM->IDLE, TX_OUT=1, busy=0, and the counter and latched data/config cleared to 0.
REQ-025 Reset SHALL take priority over Data_Valid.
REQ-026 Reset mid-frame SHALL abort the frame immediately, with no stop bit generated.

Configuration
REQ-027 Macro UART_TX_PARITY_EN defined: parity logic, PARITY state and parity_enable/parity_type SHALL be implemented as specified above.
REQ-028 Macro UART_TX_PARITY_EN undefined: no parity hardware; parity_enable/parity_type SHALL be ignored (ports kept); frames SHALL always be DATA_WD+2 bits.

Structure
REQ-029 Package uart_tx_pkg SHALL hold the FSM state enum typedef and the default DATA_WD constant.
REQ-030 Parity SHALL be computed in sub-module uart_tx_parity (data, type -> bit); FSM, counter and serializer stay in uart_tx.

Verification
REQ-031 Parity off, P_DATA=8'hA3 -> TX_OUT per cycle after busy rises: 0,1,1,0,0,0,1,0,1,1,1; busy high exactly 10 cycles.
REQ-032 Even parity, P_DATA=8'hB4 -> 0,0,0,1,0,1,1,0,1,0(parity),1; busy high 11 cycles.
REQ-033 Odd parity, P_DATA=8'hD2 -> 0,0,1,0,0,1,0,1,1,1(parity),1.
REQ-034 Data_Valid with P_DATA=8'h55 pulsed mid-frame of 8'hA3 -> frame for 8'hA3 unchanged; 8'h55 never sent.
REQ-035 RST=1 during data bit 3 -> next edge TX_OUT=1, busy=0; a new Data_Valid after release sends a complete, correct frame.
REQ-036 Data_Valid held high continuously -> frames back-to-back, separated by exactly 1 idle cycle.
